// File: rtl/demultiplexer_3_pkg.sv
// demultiplexer_3_pkg
//   Shared definitions for the mux/demux blocks: destination select codes,
//   the holding-register state encoding and a saturating counter helper.
package demultiplexer_3_pkg;

  // Destination select codes carried on in_sel.
  localparam logic [1:0] SEL_A    = 2'd0;
  localparam logic [1:0] SEL_B    = 2'd1;
  localparam logic [1:0] SEL_C    = 2'd2;
  localparam logic [1:0] SEL_DROP = 2'd3;

  // Ceiling of the 8-bit drop counter.
  localparam logic [7:0] DROP_CNT_MAX = 8'd255;

  // Holding register occupancy.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  // Increment that sticks at DROP_CNT_MAX instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    logic [7:0] result;
    if (value == DROP_CNT_MAX) begin
      result = value;
    end else begin
      result = value + 8'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/demultiplexer_3.sv
// demultiplexer_3
//   Routes one input word to one of three destinations (a, b, c) through a
//   single-entry holding register. Words addressed to SEL_DROP are accepted
//   and discarded, flagged by a one-cycle drop_err pulse and counted in a
//   saturating 8-bit drop_cnt.
//
// Ports
//   clk                      rising-edge clock
//   rst                      synchronous active-high reset
//   in_data/in_sel/in_valid  input word, destination code, valid
//   in_ready                 input accepted this cycle (combinational)
//   {a,b,c}_data/_valid      per-destination word and valid (registered)
//   {a,b,c}_ready            per-destination consume strobe
//   drop_err                 pulse one cycle after a SEL_DROP word is accepted
//   drop_cnt                 saturating count of dropped words
module demultiplexer_3
  import demultiplexer_3_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] a_data,
  output logic [WIDTH-1:0] b_data,
  output logic [WIDTH-1:0] c_data,
  output logic             a_valid,
  output logic             b_valid,
  output logic             c_valid,
  input  logic             a_ready,
  input  logic             b_ready,
  input  logic             c_ready,
  output logic             drop_err,
  output logic [7:0]       drop_cnt
);

  state_t           state_r;
  state_t           state_nxt_s;
  logic [1:0]       sel_r;
  logic [1:0]       sel_nxt_s;
  logic [WIDTH-1:0] data_r;
  logic [WIDTH-1:0] data_nxt_s;

  logic             dst_ready_s;
  logic             in_xfer_s;
  logic             out_xfer_s;
  logic             load_s;
  logic             drop_s;

  logic             a_valid_r;
  logic             b_valid_r;
  logic             c_valid_r;
  logic [WIDTH-1:0] a_data_r;
  logic [WIDTH-1:0] b_data_r;
  logic [WIDTH-1:0] c_data_r;
  logic             drop_err_r;
  logic [7:0]       drop_cnt_r;

  // Ready of the destination the held word is addressed to.
  always_comb begin
    dst_ready_s = 1'b0;
    case (sel_r)
      SEL_A:   dst_ready_s = a_ready;
      SEL_B:   dst_ready_s = b_ready;
      SEL_C:   dst_ready_s = c_ready;
      default: dst_ready_s = 1'b0;
    endcase
  end

  // Handshake qualifiers; in_ready lets a draining FULL slot refill in the
  // same cycle, and is forced low while reset is asserted.
  always_comb begin
    in_ready   = ~rst & ((state_r == ST_EMPTY) | dst_ready_s);
    in_xfer_s  = in_valid & in_ready;
    out_xfer_s = (state_r == ST_FULL) & dst_ready_s;
    load_s     = in_xfer_s & (in_sel != SEL_DROP);
    drop_s     = in_xfer_s & (in_sel == SEL_DROP);
  end

  // Next-state and holding-register update.
  always_comb begin
    state_nxt_s = state_r;
    sel_nxt_s   = sel_r;
    data_nxt_s  = data_r;
    case (state_r)
      ST_EMPTY: begin
        if (load_s) begin
          state_nxt_s = ST_FULL;
          sel_nxt_s   = in_sel;
          data_nxt_s  = in_data;
        end else begin
          state_nxt_s = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (load_s) begin
          // Drain and refill in the same cycle: no bubble.
          state_nxt_s = ST_FULL;
          sel_nxt_s   = in_sel;
          data_nxt_s  = in_data;
        end else if (out_xfer_s) begin
          state_nxt_s = ST_EMPTY;
        end else begin
          state_nxt_s = ST_FULL;
        end
      end
      default: begin
        state_nxt_s = ST_EMPTY;
      end
    endcase
  end

  // State, holding register and decoded destination outputs. Valids and
  // data are registered from the next state so they never follow x_ready
  // combinationally; unselected data lanes are driven to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_EMPTY;
      sel_r     <= SEL_A;
      data_r    <= {WIDTH{1'b0}};
      a_valid_r <= 1'b0;
      b_valid_r <= 1'b0;
      c_valid_r <= 1'b0;
      a_data_r  <= {WIDTH{1'b0}};
      b_data_r  <= {WIDTH{1'b0}};
      c_data_r  <= {WIDTH{1'b0}};
    end else begin
      state_r   <= state_nxt_s;
      sel_r     <= sel_nxt_s;
      data_r    <= data_nxt_s;
      a_valid_r <= (state_nxt_s == ST_FULL) && (sel_nxt_s == SEL_A);
      b_valid_r <= (state_nxt_s == ST_FULL) && (sel_nxt_s == SEL_B);
      c_valid_r <= (state_nxt_s == ST_FULL) && (sel_nxt_s == SEL_C);
      a_data_r  <= ((state_nxt_s == ST_FULL) && (sel_nxt_s == SEL_A)) ? data_nxt_s : {WIDTH{1'b0}};
      b_data_r  <= ((state_nxt_s == ST_FULL) && (sel_nxt_s == SEL_B)) ? data_nxt_s : {WIDTH{1'b0}};
      c_data_r  <= ((state_nxt_s == ST_FULL) && (sel_nxt_s == SEL_C)) ? data_nxt_s : {WIDTH{1'b0}};
    end
  end

  // Drop pulse and saturating drop counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_err_r <= 1'b0;
      drop_cnt_r <= 8'd0;
    end else begin
      drop_err_r <= drop_s;
      if (drop_s) begin
        drop_cnt_r <= sat_inc8(drop_cnt_r);
      end else begin
        drop_cnt_r <= drop_cnt_r;
      end
    end
  end

  assign a_valid  = a_valid_r;
  assign b_valid  = b_valid_r;
  assign c_valid  = c_valid_r;
  assign a_data   = a_data_r;
  assign b_data   = b_data_r;
  assign c_data   = c_data_r;
  assign drop_err = drop_err_r;
  assign drop_cnt = drop_cnt_r;

endmodule

// File: tb/tb_demultiplexer_3.sv
module tb_demultiplexer_3;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] in_data;
  logic [1:0]   in_sel;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a_data, b_data, c_data;
  logic         a_valid, b_valid, c_valid;
  logic         a_ready, b_ready, c_ready;
  logic         drop_err;
  logic [7:0]   drop_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: one slot that is either occupied or not.
  bit           m_full;
  logic [1:0]   m_sel;
  logic [W-1:0] m_data;
  int           m_cnt;
  bit           m_err;

  always #5 clk = ~clk;

  demultiplexer_3 #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_data   (a_data),
    .b_data   (b_data),
    .c_data   (c_data),
    .a_valid  (a_valid),
    .b_valid  (b_valid),
    .c_valid  (c_valid),
    .a_ready  (a_ready),
    .b_ready  (b_ready),
    .c_ready  (c_ready),
    .drop_err (drop_err),
    .drop_cnt (drop_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit v, input logic [1:0] s, input logic [W-1:0] d,
                       input bit ra, input bit rb, input bit rc, input bit r);
    in_valid = v;
    in_sel   = s;
    in_data  = d;
    a_ready  = ra;
    b_ready  = rb;
    c_ready  = rc;
    rst      = r;
  endtask

  task automatic check_outs();
    logic [2:0]   av;
    logic [W-1:0] ad [3];
    bit           ev;
    av    = {c_valid, b_valid, a_valid};
    ad[0] = a_data;
    ad[1] = b_data;
    ad[2] = c_data;
    for (int i = 0; i < 3; i++) begin
      ev = m_full && (int'(m_sel) == i);
      chk($sformatf("valid%0d", i), 32'(av[i]), 32'(ev));
      chk($sformatf("data%0d", i), ad[i], ev ? m_data : 32'd0);
    end
    chk("onehot", 32'($countones(av) <= 1), 32'd1);
    chk("drop_err", 32'(drop_err), 32'(m_err));
    chk("drop_cnt", 32'(drop_cnt), 32'(m_cnt));
  endtask

  // One clock: check in_ready before the edge, advance the model, check
  // registered outputs after the edge, return at the falling edge.
  task automatic cycle();
    logic [2:0] rdy;
    bit         exp_rdy, acc, outx;
    #1;
    rdy     = {c_ready, b_ready, a_ready};
    outx    = m_full && (rdy[m_sel] == 1'b1);
    exp_rdy = !rst && (!m_full || outx);
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    acc = in_valid && exp_rdy;
    @(posedge clk);
    if (rst) begin
      m_full = 1'b0; m_sel = 2'd0; m_data = '0; m_cnt = 0; m_err = 1'b0;
    end else begin
      m_err = acc && (in_sel == 2'd3);
      if (m_err && m_cnt < 255) m_cnt++;
      if (acc && in_sel != 2'd3) begin
        m_full = 1'b1; m_sel = in_sel; m_data = in_data;
      end else if (outx) begin
        m_full = 1'b0;
      end
    end
    #1;
    check_outs();
    @(negedge clk);
  endtask

  initial begin
    m_full = 1'b0; m_sel = 2'd0; m_data = '0; m_cnt = 0; m_err = 1'b0;
    drive(1'b0, 2'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    cycle();
    cycle();
    chk("reset_cnt", 32'(drop_cnt), 32'd0);

    // Single word to b.
    drive(1'b1, 2'd1, 32'hDEADBEEF, 1'b1, 1'b1, 1'b1, 1'b0);
    cycle();
    chk("req030_bvalid", 32'(b_valid), 32'd1);
    chk("req030_bdata", b_data, 32'hDEADBEEF);
    chk("req030_adata", a_data, 32'd0);
    drive(1'b0, 2'd0, 32'd0, 1'b1, 1'b1, 1'b1, 1'b0);
    cycle();

    // Back-to-back a, c, b.
    drive(1'b1, 2'd0, 32'h1, 1'b1, 1'b1, 1'b1, 1'b0); cycle();
    chk("req031_a", a_data, 32'h1);
    drive(1'b1, 2'd2, 32'h2, 1'b1, 1'b1, 1'b1, 1'b0); cycle();
    chk("req031_c", c_data, 32'h2);
    drive(1'b1, 2'd1, 32'h3, 1'b1, 1'b1, 1'b1, 1'b0); cycle();
    chk("req031_b", b_data, 32'h3);
    drive(1'b0, 2'd0, 32'd0, 1'b1, 1'b1, 1'b1, 1'b0); cycle();

    // Back-pressure on c, competing input must not overwrite.
    drive(1'b1, 2'd2, 32'h55, 1'b1, 1'b1, 1'b0, 1'b0); cycle();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 2'd0, 32'hBAD, 1'b1, 1'b1, 1'b0, 1'b0); cycle();
      chk("req032_hold", c_data, 32'h55);
    end
    drive(1'b0, 2'd0, 32'd0, 1'b1, 1'b1, 1'b1, 1'b0); cycle();
    chk("req032_drained", 32'(c_valid), 32'd0);

    // 300 dropped words, counter saturates.
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 2'd3, $urandom, 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
      cycle();
    end
    chk("req033_sat", 32'(drop_cnt), 32'd255);
    drive(1'b0, 2'd0, 32'd0, 1'b1, 1'b1, 1'b1, 1'b0); cycle();

    // Reset discards a held word.
    drive(1'b1, 2'd0, 32'h77, 1'b0, 1'b0, 1'b0, 1'b0); cycle();
    drive(1'b0, 2'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1); cycle();
    chk("req034_avalid", 32'(a_valid), 32'd0);
    chk("req034_cnt", 32'(drop_cnt), 32'd0);
    drive(1'b0, 2'd0, 32'd0, 1'b1, 1'b1, 1'b1, 1'b0); cycle();

    // Drain b and refill a in the same cycle.
    drive(1'b1, 2'd1, 32'h8, 1'b0, 1'b0, 1'b0, 1'b0); cycle();
    drive(1'b1, 2'd0, 32'h9, 1'b0, 1'b1, 1'b0, 1'b0); cycle();
    chk("req035_avalid", 32'(a_valid), 32'd1);
    chk("req035_adata", a_data, 32'h9);

    // Drain a while a dropped word arrives: slot empties, drop counted.
    drive(1'b1, 2'd3, 32'hF, 1'b1, 1'b0, 1'b0, 1'b0); cycle();
    chk("req020_empty", 32'(a_valid), 32'd0);
    chk("req020_err", 32'(drop_err), 32'd1);

    // Randomized traffic with occasional reset.
    for (int i = 0; i < 600; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 2'($urandom), $urandom,
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 2) != 0), $urandom_range(0, 49) == 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
